// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM controller port among NUM_REQ
// bursting masters. A grant is held for a whole burst, and only one transaction
// is outstanding at a time, so read data is routed to the owner without a queue.
module sdram_port_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned BURST_W = 4
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
  input  logic [NUM_REQ*BURST_W-1:0]  req_burstcount,
  output logic [NUM_REQ-1:0]          req_waitrequest,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_readdatavalid,
  output logic [ADDR_W-1:0]           avm_address,
  output logic                        avm_read,
  output logic                        avm_write,
  output logic [DATA_W-1:0]           avm_writedata,
  output logic [BURST_W-1:0]          avm_burstcount,
  input  logic                        avm_waitrequest,
  input  logic [DATA_W-1:0]           avm_readdata,
  input  logic                        avm_readdatavalid,
  output logic [NUM_REQ-1:0]          grant_onehot
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StGrant   = 2'd1;
  localparam logic [1:0] StWrBurst = 2'd2;
  localparam logic [1:0] StRdWait  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [IdxW-1:0]    gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;

  logic               win_found;
  logic [IdxW-1:0]    win_idx;
  logic               g_rd, g_wr;
  logic [BURST_W-1:0] g_bc_raw, g_bc_eff;
  logic [IdxW-1:0]    ptr_after;

  // Round-robin search starting at ptr_q
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      int j;
      j = (int'(ptr_q) + k) % int'(NUM_REQ);
      if (!win_found && (req_read[j] || req_write[j])) begin
        win_found = 1'b1;
        win_idx   = IdxW'(j);
      end
    end
  end

  // Granted requester's command fields; burstcount 0 behaves as a single beat
  always_comb begin
    g_rd      = req_read[gidx_q];
    g_wr      = req_write[gidx_q];
    g_bc_raw  = req_burstcount[gidx_q*BURST_W +: BURST_W];
    g_bc_eff  = (g_bc_raw == '0) ? BURST_W'(1) : g_bc_raw;
    ptr_after = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  end

  // Output mux: pass the owner through while a command may be issued
  always_comb begin
    avm_read          = 1'b0;
    avm_write         = 1'b0;
    avm_address       = '0;
    avm_writedata     = '0;
    avm_burstcount    = BURST_W'(1);
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    case (state_q)
      StGrant, StWrBurst: begin
        avm_write                = g_wr;
        // Write wins when both are raised; reads only start from GRANT
        avm_read                 = (state_q == StGrant) ? (g_rd & ~g_wr) : 1'b0;
        avm_address              = req_address[gidx_q*ADDR_W +: ADDR_W];
        avm_writedata            = req_writedata[gidx_q*DATA_W +: DATA_W];
        avm_burstcount           = g_bc_eff;
        req_waitrequest[gidx_q]  = avm_waitrequest;
      end
      StRdWait: begin
        req_readdatavalid[gidx_q] = avm_readdatavalid;
      end
      default: ;
    endcase
  end

  assign req_readdata = avm_readdata;
  assign grant_onehot = grant_q;

  // Next-state: grant selection, burst beat counting and release
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          gidx_d           = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          state_d          = StGrant;
        end
      end
      StGrant: begin
        if (g_wr) begin
          if (!avm_waitrequest) begin
            cnt_d = g_bc_eff - BURST_W'(1);
            if (g_bc_eff == BURST_W'(1)) begin
              state_d = StIdle;
              grant_d = '0;
              ptr_d   = ptr_after;
            end else begin
              state_d = StWrBurst;
            end
          end
        end else if (g_rd) begin
          if (!avm_waitrequest) begin
            cnt_d   = g_bc_eff;
            state_d = StRdWait;
          end
        end else begin
          // Request withdrawn before acceptance: give up without advancing ptr
          state_d = StIdle;
          grant_d = '0;
        end
      end
      StWrBurst: begin
        if (g_wr && !avm_waitrequest) begin
          cnt_d = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) begin
            state_d = StIdle;
            grant_d = '0;
            ptr_d   = ptr_after;
          end
        end
      end
      StRdWait: begin
        if (avm_readdatavalid) begin
          cnt_d = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) begin
            state_d = StIdle;
            grant_d = '0;
            ptr_d   = ptr_after;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sdram_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 16;
  localparam int BURST_W = 4;

  logic                       clk_clk = 1'b0;
  logic                       reset_reset = 1'b1;
  logic [NUM_REQ*ADDR_W-1:0]  req_address = '0;
  logic [NUM_REQ-1:0]         req_read = '0;
  logic [NUM_REQ-1:0]         req_write = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_writedata = '0;
  logic [NUM_REQ*BURST_W-1:0] req_burstcount = '0;
  logic [NUM_REQ-1:0]         req_waitrequest;
  logic [DATA_W-1:0]          req_readdata;
  logic [NUM_REQ-1:0]         req_readdatavalid;
  logic [ADDR_W-1:0]          avm_address;
  logic                       avm_read;
  logic                       avm_write;
  logic [DATA_W-1:0]          avm_writedata;
  logic [BURST_W-1:0]         avm_burstcount;
  logic                       avm_waitrequest = 1'b0;
  logic [DATA_W-1:0]          avm_readdata = '0;
  logic                       avm_readdatavalid = 1'b0;
  logic [NUM_REQ-1:0]         grant_onehot;

  sdram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)
  ) dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .req_address      (req_address),
    .req_read         (req_read),
    .req_write        (req_write),
    .req_writedata    (req_writedata),
    .req_burstcount   (req_burstcount),
    .req_waitrequest  (req_waitrequest),
    .req_readdata     (req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_burstcount   (avm_burstcount),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .grant_onehot     (grant_onehot)
  );

  always #5 clk_clk = ~clk_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner (-1 = nobody), remaining write/read beats, round-robin pointer
  int m_own = -1;
  int m_ptr = 0;
  int m_wr_left = 0;
  int m_rd_left = 0;

  function automatic int eff_bc(input int i);
    int b;
    b = int'(req_burstcount[i*BURST_W +: BURST_W]);
    return (b == 0) ? 1 : b;
  endfunction

  task automatic m_release();
    m_ptr     = (m_own + 1) % NUM_REQ;
    m_own     = -1;
    m_wr_left = 0;
    m_rd_left = 0;
  endtask

  initial forever begin
    @(posedge clk_clk or posedge reset_reset);
    if (reset_reset) begin
      m_own = -1; m_ptr = 0; m_wr_left = 0; m_rd_left = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (m_ptr + k) % NUM_REQ;
        if (m_own < 0 && (req_read[j] || req_write[j])) m_own = j;
      end
    end else if (m_rd_left > 0) begin
      if (avm_readdatavalid) begin
        m_rd_left--;
        if (m_rd_left == 0) m_release();
      end
    end else if (m_wr_left > 0) begin
      if (req_write[m_own] && !avm_waitrequest) begin
        m_wr_left--;
        if (m_wr_left == 0) m_release();
      end
    end else begin
      if (req_write[m_own]) begin
        if (!avm_waitrequest) begin
          if (eff_bc(m_own) == 1) m_release();
          else m_wr_left = eff_bc(m_own) - 1;
        end
      end else if (req_read[m_own]) begin
        if (!avm_waitrequest) m_rd_left = eff_bc(m_own);
      end else begin
        m_own = -1;
      end
    end
  end

  // Observation logs for the directed scenarios
  int rdv_cnt[NUM_REQ];
  int acc_own[$];
  int acc_dat[$];

  // Every-cycle comparison against the model, sampled on the falling edge
  initial begin
    for (int i = 0; i < NUM_REQ; i++) rdv_cnt[i] = 0;
    forever begin
      logic [NUM_REQ-1:0] e_gnt, e_wreq, e_rdv;
      logic               e_rd, e_wr;
      logic [ADDR_W-1:0]  e_addr;
      logic [DATA_W-1:0]  e_dat;
      logic [BURST_W-1:0] e_bc;
      @(negedge clk_clk);
      e_gnt = '0; e_wreq = '1; e_rdv = '0; e_rd = 1'b0; e_wr = 1'b0;
      e_addr = '0; e_dat = '0; e_bc = BURST_W'(1);
      if (m_own >= 0) e_gnt[m_own] = 1'b1;
      if (m_own >= 0 && m_rd_left == 0) begin
        e_wr  = req_write[m_own];
        e_rd  = (m_wr_left == 0) && req_read[m_own] && !req_write[m_own];
        e_addr = req_address[m_own*ADDR_W +: ADDR_W];
        e_dat  = req_writedata[m_own*DATA_W +: DATA_W];
        e_bc   = BURST_W'(eff_bc(m_own));
        e_wreq[m_own] = avm_waitrequest;
      end
      if (m_rd_left > 0) e_rdv[m_own] = avm_readdatavalid;
      chk("model grant_onehot", 64'(grant_onehot), 64'(e_gnt));
      chk("model avm_read", 64'(avm_read), 64'(e_rd));
      chk("model avm_write", 64'(avm_write), 64'(e_wr));
      chk("model avm_address", 64'(avm_address), 64'(e_addr));
      chk("model avm_writedata", 64'(avm_writedata), 64'(e_dat));
      chk("model avm_burstcount", 64'(avm_burstcount), 64'(e_bc));
      chk("model req_waitrequest", 64'(req_waitrequest), 64'(e_wreq));
      chk("model req_readdatavalid", 64'(req_readdatavalid), 64'(e_rdv));
      chk("model req_readdata", 64'(req_readdata), 64'(avm_readdata));
      for (int i = 0; i < NUM_REQ; i++) if (req_readdatavalid[i]) rdv_cnt[i]++;
      if (avm_write && !avm_waitrequest) begin
        acc_own.push_back(grant_onehot[1] ? 1 : 0);
        acc_dat.push_back(int'(avm_writedata));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  initial begin
    int n0, s2, s5, r0, r1;
    // 1: reset values, then idle with no requests
    tick(); tick();
    chk("rst grant", 64'(grant_onehot), 64'h0);
    chk("rst waitreq", 64'(req_waitrequest), 64'h3);
    chk("rst burstcount", 64'(avm_burstcount), 64'h1);
    chk("rst rd/wr", 64'({avm_read, avm_write}), 64'h0);
    reset_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle grant", 64'(grant_onehot), 64'h0);
    end

    // 2: requester 1 reads 4 beats at 0x100
    req_address[ADDR_W +: ADDR_W] = 25'h100;
    req_burstcount[BURST_W +: BURST_W] = 4'd4;
    req_read = 2'b10;
    tick();
    chk("t2 grant", 64'(grant_onehot), 64'h2);
    chk("t2 address", 64'(avm_address), 64'h100);
    chk("t2 read", 64'(avm_read), 64'h1);
    tick();
    req_read = 2'b00;
    for (int k = 0; k < 4; k++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = DATA_W'(16'hA0 + k);
      tick();
    end
    avm_readdatavalid = 1'b0;
    chk("t2 beats on 1", 64'(rdv_cnt[1]), 64'd4);
    chk("t2 beats on 0", 64'(rdv_cnt[0]), 64'd0);
    chk("t2 back idle", 64'(grant_onehot), 64'h0);
    tick();

    // 3: both masters stream single-beat writes
    acc_own.delete(); acc_dat.delete();
    req_burstcount = {4'd1, 4'd1};
    req_writedata = {16'h2222, 16'h1111};
    req_write = 2'b11;
    for (int c = 0; c < 40 && acc_own.size() < 6; c++) tick();
    req_write = 2'b00;
    chk("t3 accepted count", 64'(acc_own.size() >= 6), 64'h1);
    if (acc_own.size() >= 6)
      for (int k = 0; k < 6; k++) chk("t3 order", 64'(acc_own[k]), 64'(k % 2));
    tick(); tick();

    // 4: 8-beat burst from 0 with two stalls, 1 waiting throughout
    acc_own.delete(); acc_dat.delete();
    req_burstcount = {4'd1, 4'd8};
    req_writedata = {16'hBEEF, 16'h0400};
    req_write = 2'b11;
    s2 = 0; s5 = 0;
    for (int c = 0; c < 60; c++) begin
      n0 = 0;
      foreach (acc_own[k]) if (acc_own[k] == 0) n0++;
      if (acc_own.size() > n0) break;
      if (n0 >= 8) req_write[0] = 1'b0;
      req_writedata[DATA_W-1:0] = DATA_W'(16'h0400 + n0);
      if (n0 == 2 && s2 == 0) begin avm_waitrequest = 1'b1; s2 = 1; end
      else if (n0 == 5 && s5 == 0) begin avm_waitrequest = 1'b1; s5 = 1; end
      else avm_waitrequest = 1'b0;
      tick();
    end
    req_write = 2'b00;
    avm_waitrequest = 1'b0;
    chk("t4 beat count", 64'(acc_own.size()), 64'd9);
    if (acc_own.size() == 9) begin
      for (int k = 0; k < 8; k++) begin
        chk("t4 beat owner", 64'(acc_own[k]), 64'd0);
        chk("t4 beat data", 64'(acc_dat[k]), 64'(16'h0400 + k));
      end
      chk("t4 req1 after burst", 64'(acc_own[8]), 64'd1);
    end
    tick(); tick();

    // 5: reset in the middle of a 4-beat read
    req_address[ADDR_W-1:0] = 25'h200;
    req_burstcount = {4'd1, 4'd4};
    req_read = 2'b01;
    tick(); tick();
    req_read = 2'b00;
    r0 = rdv_cnt[0];
    avm_readdatavalid = 1'b1; tick(); tick();
    avm_readdatavalid = 1'b0;
    reset_reset = 1'b1;
    #1;
    chk("t5 rst grant", 64'(grant_onehot), 64'h0);
    chk("t5 rst waitreq", 64'(req_waitrequest), 64'h3);
    chk("t5 rst rdv", 64'(req_readdatavalid), 64'h0);
    chk("t5 rst burstcount", 64'(avm_burstcount), 64'h1);
    tick();
    reset_reset = 1'b0;
    avm_readdatavalid = 1'b1; tick(); tick();
    avm_readdatavalid = 1'b0;
    tick();
    chk("t5 forwarded beats", 64'(rdv_cnt[0] - r0), 64'd2);

    // 6: burstcount 0 read behaves as one beat, pointer advances to 1
    req_address[ADDR_W-1:0] = 25'h300;
    req_burstcount = {4'd1, 4'd0};
    req_read = 2'b01;
    tick();
    chk("t6 burstcount", 64'(avm_burstcount), 64'h1);
    tick();
    req_read = 2'b00;
    r0 = rdv_cnt[0];
    r1 = rdv_cnt[1];
    avm_readdatavalid = 1'b1; tick();
    avm_readdatavalid = 1'b0;
    chk("t6 one beat", 64'(rdv_cnt[0] - r0), 64'd1);
    chk("t6 none on 1", 64'(rdv_cnt[1] - r1), 64'd0);
    chk("t6 idle", 64'(grant_onehot), 64'h0);
    chk("t6 model ptr", 64'(m_ptr), 64'd1);
    // Both request; pointer at 1 so master 1 wins, write beats read
    avm_waitrequest = 1'b1;
    req_read = 2'b11;
    req_write = 2'b10;
    tick();
    chk("t6 grant after ptr", 64'(grant_onehot), 64'h2);
    chk("t6 write wins", 64'(avm_write), 64'h1);
    chk("t6 read ignored", 64'(avm_read), 64'h0);
    // Withdraw before acceptance: pointer stays at 1
    req_read = 2'b00; req_write = 2'b00;
    tick();
    chk("t6 withdrawn", 64'(grant_onehot), 64'h0);
    req_read = 2'b11;
    tick();
    chk("t6 ptr kept", 64'(grant_onehot), 64'h2);
    req_read = 2'b00;
    avm_waitrequest = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
